// File: rtl/vram_arbiter.sv
// VRAM arbiter: VGA scan-out reads, blocking CPU reads and posted CPU writes.
// Optional `VRAM_ARB_STATS_EN adds saturating miss/forced/write-full counters.
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 12,
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_wr_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]       stat_miss,
    output logic [15:0]       stat_forced,
    output logic [15:0]       stat_wfull,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        G_NONE,
        G_VGA,
        G_RD,
        G_WR
    } grant_t;

    logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [PW-1:0]     rd_idx;
    logic              wb_empty;
    logic              wb_full;

    logic [CW-1:0]     starve_cnt;
    logic              rd_busy;
    logic              rd_ok;
    logic              pending;
    logic              forced;
    logic              push;
    logic              pop;
    grant_t            grant;

    logic              p_vga;
    logic              p_cpu;
    logic              p_miss;

    assign rd_idx   = rd_ptr[PW-1:0];
    assign wb_empty = (wr_ptr == rd_ptr);
    assign wb_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign cpu_wr_ack = cpu_we & ~wb_full;
    assign push       = cpu_wr_ack;
    assign pop        = (grant == G_WR);

    // Reads wait for an empty buffer so they observe every posted write.
    assign rd_ok   = cpu_re & ~rd_busy & wb_empty;
    assign pending = ~wb_empty | (cpu_re & ~rd_busy);

    always_comb begin
        grant  = G_NONE;
        forced = 1'b0;
        if ((starve_cnt == CW'(STARVE_LIMIT)) && pending) begin
            forced = 1'b1;
            grant  = rd_ok ? G_RD : G_WR;
        end else if (vga_req) begin
            grant = G_VGA;
        end else if (rd_ok) begin
            grant = G_RD;
        end else if (~wb_empty) begin
            grant = G_WR;
        end
    end

    always_comb begin
        mem_en    = rst_n & (grant != G_NONE);
        mem_we    = rst_n & (grant == G_WR);
        mem_addr  = '0;
        mem_wdata = wb_data[rd_idx];
        unique case (grant)
            G_VGA:   mem_addr = vga_addr;
            G_RD:    mem_addr = cpu_addr;
            G_WR:    mem_addr = wb_addr[rd_idx];
            default: mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr[PW-1:0]] <= cpu_addr;
            wb_data[wr_ptr[PW-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            rd_busy    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if ((grant == G_RD) || (grant == G_WR))
                starve_cnt <= '0;
            else if (pending && (starve_cnt != CW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;
            // Busy spans issue through the valid pulse to stop a re-grant.
            if (grant == G_RD)
                rd_busy <= 1'b1;
            else if (cpu_rd_valid)
                rd_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vga        <= 1'b0;
            p_cpu        <= 1'b0;
            p_miss       <= 1'b0;
            vga_valid    <= 1'b0;
            vga_miss     <= 1'b0;
            cpu_rd_valid <= 1'b0;
            vga_data     <= '0;
            cpu_rdata    <= '0;
        end else begin
            p_vga        <= (grant == G_VGA);
            p_cpu        <= (grant == G_RD);
            p_miss       <= forced & vga_req;
            vga_valid    <= p_vga;
            vga_miss     <= p_miss;
            cpu_rd_valid <= p_cpu;
            if (p_vga) vga_data  <= mem_rdata;
            if (p_cpu) cpu_rdata <= mem_rdata;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_miss   <= '0;
            stat_forced <= '0;
            stat_wfull  <= '0;
        end else begin
            if (vga_miss && (stat_miss != 16'hFFFF))
                stat_miss <= stat_miss + 1'b1;
            if (forced && (stat_forced != 16'hFFFF))
                stat_forced <= stat_forced + 1'b1;
            if (cpu_we && wb_full && (stat_wfull != 16'hFFFF))
                stat_wfull <= stat_wfull + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model and read scoreboards.
// Define VRAM_ARB_STATS_EN to also check the statistics counters.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_req, vga_valid, vga_miss;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          cpu_we, cpu_re, cpu_wr_ack, cpu_rd_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stat_miss, stat_forced, stat_wfull;
`endif

    vram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .vga_miss     (vga_miss),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wr_ack   (cpu_wr_ack),
        .cpu_rdata    (cpu_rdata),
        .cpu_rd_valid (cpu_rd_valid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
`ifdef VRAM_ARB_STATS_EN
        .stat_miss    (stat_miss),
        .stat_forced  (stat_forced),
        .stat_wfull   (stat_wfull),
`endif
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] vram  [0:(1<<AW)-1];
    logic [DW-1:0] model [0:(1<<AW)-1];
    logic [DW-1:0] vga_q [$];
    logic [DW-1:0] cpu_q [$];
    logic [DW-1:0] last_vga = '0;
    int n_chk  = 0;
    int n_fail = 0;
    int vga_vcnt = 0;
    int vga_mcnt = 0;
    int cpu_vcnt = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 3 + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop side: every VGA result slot and every CPU read pulse.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (vga_valid || vga_miss) begin
            check("vga_valid_and_miss", {31'd0, vga_valid & vga_miss}, 32'd0);
            if (vga_q.size() == 0) begin
                check("vga_unexpected", 32'd1, 32'd0);
            end else begin
                e = vga_q.pop_front();
                if (vga_valid) begin
                    vga_vcnt++;
                    check("vga_data", {20'd0, vga_data}, {20'd0, e});
                    last_vga = e;
                end else begin
                    vga_mcnt++;
                    check("vga_miss_hold", {20'd0, vga_data}, {20'd0, last_vga});
                end
            end
        end
        if (cpu_rd_valid) begin
            cpu_vcnt++;
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected", 32'd1, 32'd0);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_rdata", {20'd0, cpu_rdata}, {20'd0, e});
            end
        end
    end

    task automatic wait_cpu(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_rd_valid && n < 40);
    endtask

    task automatic idle();
        vga_req = 0; vga_addr = '0;
        cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    initial begin
        int n;
        int wi;
        int ack_cyc [5];
        logic acked;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]  = pat(i);
            model[i] = pat(i);
        end
        idle();
        vga_req = 1; vga_addr = 13'd3; cpu_re = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_vga_data",  {20'd0, vga_data}, 32'd0);
        check("rst_cpu_rdata", {20'd0, cpu_rdata}, 32'd0);
        check("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
        check("rst_vga_miss",  {31'd0, vga_miss}, 32'd0);
        check("rst_cpu_valid", {31'd0, cpu_rd_valid}, 32'd0);
        check("rst_mem_en",    {31'd0, mem_en}, 32'd0);
        check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1;

        // Single write then read-back on an idle VGA side
        @(negedge clk);
        cpu_we = 1; cpu_addr = 13'h005; cpu_wdata = 12'hABC;
        model[5] = 12'hABC;
        #1;
        check("t1_wr_ack", {31'd0, cpu_wr_ack}, 32'd1);
        check("t1_no_acc", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        cpu_we = 0;
        #1;
        check("t1_mem_en", {31'd0, mem_en}, 32'd1);
        check("t1_mem_we", {31'd0, mem_we}, 32'd1);
        check("t1_mem_addr", {19'd0, mem_addr}, 32'h005);
        check("t1_mem_wdata", {20'd0, mem_wdata}, 32'hABC);
        @(negedge clk);
        cpu_re = 1; cpu_addr = 13'h005;
        cpu_q.push_back(model[5]);
        wait_cpu(n);
        check("t1_rd_latency", n, 2);
        @(negedge clk);
        cpu_re = 0;
        repeat (3) @(negedge clk);
        check("t1_single_pulse", cpu_vcnt, 1);

        // Continuous VGA stream over addresses 0..15
        vga_vcnt = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 1) check("t2_first_gap", {31'd0, vga_valid}, 32'd0);
            if (i >= 2) check("t2_stream_valid", {31'd0, vga_valid}, 32'd1);
            if (i < 16) begin
                vga_req = 1; vga_addr = AW'(i);
                vga_q.push_back(model[i]);
            end else begin
                vga_req = 0;
            end
        end
        repeat (2) @(negedge clk);
        check("t2_valid_cnt", vga_vcnt, 16);
        check("t2_miss_cnt", vga_mcnt, 0);

        // VGA saturating the port while five writes are posted
        vga_mcnt = 0; wi = 0; acked = 0;
        foreach (ack_cyc[k]) ack_cyc[k] = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (acked) wi++;
            vga_req = 1; vga_addr = AW'(13'h100 + c);
            vga_q.push_back(model[13'h100 + c]);
            cpu_we = (wi < 5);
            cpu_addr = AW'(13'h200 + wi);
            cpu_wdata = DW'(12'h900 + wi);
            if (wi < 5) model[13'h200 + wi] = DW'(12'h900 + wi);
            #1;
            acked = cpu_wr_ack;
            if (acked) ack_cyc[wi] = c;
            if (c == 9) begin
                check("t3_forced_we", {31'd0, mem_we}, 32'd1);
                check("t3_forced_addr", {19'd0, mem_addr}, 32'h200);
            end
            if (c == 10) check("t3_no_miss_yet", vga_mcnt, 0);
            if (c == 11) check("t3_first_miss", vga_mcnt, 1);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("t3_ack3_cyc", ack_cyc[3], 3);
        check("t3_ack4_cyc", ack_cyc[4], 10);
        check("t3_miss_cnt", vga_mcnt, 5);
        check("t3_vga_q_empty", vga_q.size(), 0);
`ifdef VRAM_ARB_STATS_EN
        check("t3_stat_forced", {16'd0, stat_forced}, 32'd5);
        check("t3_stat_miss", {16'd0, stat_miss}, 32'd5);
        check("t3_stat_wfull", {16'd0, stat_wfull}, 32'd6);
`endif
        cpu_re = 1; cpu_addr = 13'h204;
        cpu_q.push_back(model[13'h204]);
        wait_cpu(n);
        check("t3_rd_latency", n, 2);
        @(negedge clk);
        cpu_re = 0;

        // Read-after-write ordering through the posted buffer
        @(negedge clk);
        vga_req = 1; vga_addr = 13'h020; vga_q.push_back(model[13'h020]);
        cpu_we = 1; cpu_addr = 13'h050; cpu_wdata = 12'h111;
        #1;
        check("t4_ack0", {31'd0, cpu_wr_ack}, 32'd1);
        @(negedge clk);
        vga_addr = 13'h021; vga_q.push_back(model[13'h021]);
        cpu_wdata = 12'h222;
        #1;
        check("t4_ack1", {31'd0, cpu_wr_ack}, 32'd1);
        @(negedge clk);
        vga_addr = 13'h022; vga_q.push_back(model[13'h022]);
        cpu_we = 0; cpu_re = 1;
        model[13'h050] = 12'h222;
        cpu_q.push_back(12'h222);
        #1;
        check("t4_rd_blocked", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        vga_addr = 13'h023; vga_q.push_back(model[13'h023]);
        @(negedge clk);
        vga_req = 0;
        #1;
        check("t4_drain0", {20'd0, mem_wdata}, 32'h111);
        @(negedge clk);
        #1;
        check("t4_drain1", {20'd0, mem_wdata}, 32'h222);
        check("t4_drain1_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        #1;
        check("t4_read_en", {31'd0, mem_en}, 32'd1);
        check("t4_read_we", {31'd0, mem_we}, 32'd0);
        wait_cpu(n);
        check("t4_rd_latency", n, 2);
        @(negedge clk);
        cpu_re = 0;
        repeat (2) @(negedge clk);

        // Reset while a read is in flight and a write is buffered
        n = cpu_vcnt;
        @(negedge clk);
        cpu_re = 1; cpu_addr = 13'h005;
        cpu_we = 1; cpu_wdata = 12'h555;
        @(negedge clk);
        cpu_we = 0;
        vga_req = 1; vga_addr = 13'h030;
        #2;
        rst_n = 0;
        @(negedge clk);
        #1;
        check("t5_rst_cpu_valid", {31'd0, cpu_rd_valid}, 32'd0);
        check("t5_rst_vga_data", {20'd0, vga_data}, 32'd0);
        check("t5_rst_cpu_rdata", {20'd0, cpu_rdata}, 32'd0);
        check("t5_rst_mem_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t5_fifo_empty", {31'd0, mem_en}, 32'd0);
        end
        check("t5_no_rd_valid", cpu_vcnt, n);
        check("t5_vga_q_empty", vga_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
